// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI full-burst master and its beat checker.
package axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWdata,
        StWresp,
        StRaddr,
        StRdata,
        StDone
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AxSIZE encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] size_from_width(input int unsigned width);
        int unsigned bytes;
        logic [2:0]  sz;
        bytes = width / 8;
        sz    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bytes == (32'd1 << i)) begin
                sz = 3'(i);
            end
        end
        return sz;
    endfunction

endpackage

// File: rtl/axi_beat_checker.sv
// Compares returned read beats and the write response against expectations and keeps
// a saturating per-test error count.
module axi_beat_checker
    import axi_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              bresp_en_i,
    input  logic [1:0]        bresp_i,
    input  logic              beat_en_i,
    input  logic [DATA_W-1:0] exp_data_i,
    input  logic              exp_last_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    output logic [7:0]        err_cnt_o,
    output logic              error_o
);

    logic       beat_bad;
    logic       bresp_bad;
    logic       err_event;
    logic [7:0] cnt_d;
    logic [7:0] cnt_q;
    logic       error_q;

    // Several faults within one beat still count as a single error.
    always_comb begin
        beat_bad  = beat_en_i && ((rdata_i != exp_data_i) || (rresp_i != RESP_OKAY) ||
                                  (rlast_i != exp_last_i));
        bresp_bad = bresp_en_i && (bresp_i != RESP_OKAY);
        err_event = beat_bad || bresp_bad;
        cnt_d     = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (err_event && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= 8'd0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= (cnt_d != 8'd0);
        end
    end

    assign err_cnt_o = cnt_q;
    assign error_o   = error_q;

endmodule

// File: rtl/axi_full_burst_master.sv
// AXI4 master that writes one INCR burst of an incrementing pattern, reads it back,
// and reports the number of mismatches seen.
module axi_full_burst_master
    import axi_pkg::*;
#(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 6,
    parameter int unsigned C_M_AXI_BURST_LEN  = 4
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_base_addr,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_error,
    output logic [7:0]                        o_err_cnt,
    output logic                              M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic                              M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic                              M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic                              M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned DATA_W    = C_M_AXI_DATA_WIDTH;
    localparam int unsigned ADDR_W    = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam logic [7:0]  LAST_BEAT = 8'(C_M_AXI_BURST_LEN - 1);
    localparam logic [2:0]  AXI_SIZE  = size_from_width(DATA_W);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          beat_q;
    logic [7:0]          beat_inc;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                wlast_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                bready_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                busy_q;
    logic                done_q;

    logic                start_accept;
    logic                bresp_en;
    logic                beat_en;
    logic [DATA_W-1:0]   exp_data;
    logic                exp_last;
    logic                unused_ids;

    assign beat_inc     = (beat_q != 8'hFF) ? beat_q + 8'd1 : beat_q;
    assign start_accept = (state_q == StIdle) && i_start;
    assign bresp_en     = (state_q == StWresp) && bready_q && M_AXI_BVALID;
    assign beat_en      = (state_q == StRdata) && rready_q && M_AXI_RVALID;
    assign exp_data     = DATA_W'(beat_q) + DATA_W'(1);
    assign exp_last     = (beat_q == LAST_BEAT);
    assign unused_ids   = M_AXI_BID ^ M_AXI_RID;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            beat_q    <= 8'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            wdata_q   <= '0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q   <= StWaddr;
                        addr_q    <= i_base_addr;
                        awvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                StWaddr: begin
                    if (awvalid_q && M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= DATA_W'(1);
                        wlast_q   <= (LAST_BEAT == 8'd0);
                        beat_q    <= 8'd0;
                        state_q   <= StWdata;
                    end
                end
                StWdata: begin
                    if (wvalid_q && M_AXI_WREADY) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            wdata_q  <= '0;
                            bready_q <= 1'b1;
                            state_q  <= StWresp;
                        end else begin
                            beat_q  <= beat_inc;
                            wdata_q <= DATA_W'(beat_inc) + DATA_W'(1);
                            wlast_q <= (beat_inc == LAST_BEAT);
                        end
                    end
                end
                StWresp: begin
                    if (bready_q && M_AXI_BVALID) begin
                        bready_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                        state_q   <= StRaddr;
                    end
                end
                StRaddr: begin
                    if (arvalid_q && M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_q    <= 8'd0;
                        state_q   <= StRdata;
                    end
                end
                StRdata: begin
                    // Exit is decided by the beat count; RLAST only feeds the checker.
                    if (rready_q && M_AXI_RVALID) begin
                        if (beat_q == LAST_BEAT) begin
                            rready_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            beat_q <= beat_inc;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    axi_beat_checker #(
        .DATA_W (DATA_W)
    ) u_checker (
        .clk_i      (M_AXI_ACLK),
        .rst_ni     (M_AXI_ARESETN),
        .clear_i    (start_accept),
        .bresp_en_i (bresp_en),
        .bresp_i    (M_AXI_BRESP),
        .beat_en_i  (beat_en),
        .exp_data_i (exp_data),
        .exp_last_i (exp_last),
        .rdata_i    (M_AXI_RDATA),
        .rresp_i    (M_AXI_RRESP),
        .rlast_i    (M_AXI_RLAST),
        .err_cnt_o  (o_err_cnt),
        .error_o    (o_error)
    );

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign M_AXI_AWID    = 1'b0;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = LAST_BEAT;
    assign M_AXI_AWSIZE  = AXI_SIZE;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = {STRB_W{1'b1}};
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = LAST_BEAT;
    assign M_AXI_ARSIZE  = AXI_SIZE;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
